riscv_dmem_ctrl: RTL and testbench

//  Data-memory stage sitting directly downstream of the core's load/store port.
//  - Serves the core's byte address (mem_addr), en, rw and 32-bit write data; returns 32-bit read data.
//  - Backing store is an internal word-organised RAM.
//  - Zero-fills the RAM after reset, flags bad accesses, keeps saturating read/write access counters.

---
 rtl/riscv_dmem_ctrl_if.sv | 25 ++
 rtl/riscv_dmem_ctrl.sv | 102 ++++++++++
 tb/tb_riscv_dmem_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_dmem_ctrl_if.sv
// Load/store bus between the core and the data-memory stage.
// The master side is the core and the slave side is riscv_dmem_ctrl.
interface riscv_dmem_ctrl_if #(
    parameter int CNT_W = 16
) ();
    logic [31:0]      mem_addr;
    logic             en;
    logic             rw;
    logic [31:0]      ddatout;
    logic [31:0]      ddatin;
    logic             busy;
    logic             err;
    logic [CNT_W-1:0] rd_cnt;
    logic [CNT_W-1:0] wr_cnt;

    modport master (
        output mem_addr, en, rw, ddatout,
        input  ddatin, busy, err, rd_cnt, wr_cnt
    );

    modport slave (
        input  mem_addr, en, rw, ddatout,
        output ddatin, busy, err, rd_cnt, wr_cnt
    );
endinterface

// File: rtl/riscv_dmem_ctrl.sv
// Data-memory stage: word RAM with post-reset zero-fill and saturating counters.
// Optional parity bit per word when DMEM_PARITY_EN is defined.
module riscv_dmem_ctrl #(
    parameter int AW    = 10,
    parameter int CNT_W = 16
) (
    input logic             clk,
    input logic             rst,
    riscv_dmem_ctrl_if.slave bus
);
    localparam int DEPTH = 1 << AW;
`ifdef DMEM_PARITY_EN
    localparam int DW = 33;
`else
    localparam int DW = 32;
`endif

    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_IDLE  = 1'b1;

    logic [0:0]       state;
    logic [AW-1:0]    clr_ptr;
    logic [DW-1:0]    mem [DEPTH];
    logic [AW-1:0]    idx;
    logic             in_range;
    logic             idle;
    logic             acc_wr;
    logic             acc_rd;
    logic             par_err;
    logic [DW-1:0]    rd_word;
    logic [DW-1:0]    wr_word;
    logic [31:0]      ddatin;
    logic             err;
    logic [CNT_W-1:0] rd_cnt;
    logic [CNT_W-1:0] wr_cnt;
    logic             unused_ok;

    assign idx      = bus.mem_addr[AW+1:2];
    assign in_range = (bus.mem_addr[31:AW+2] == '0);
    assign idle     = (state == S_IDLE);
    assign acc_wr   = idle & bus.en & in_range & bus.rw;
    assign acc_rd   = idle & bus.en & in_range & ~bus.rw;
    assign rd_word  = mem[idx];
    assign unused_ok = ^bus.mem_addr[1:0];

`ifdef DMEM_PARITY_EN
    assign wr_word = {^bus.ddatout, bus.ddatout};
    assign par_err = acc_rd & (^rd_word);
`else
    assign wr_word = bus.ddatout;
    assign par_err = 1'b0;
`endif

    assign bus.busy   = ~idle;
    assign bus.ddatin = ddatin;
    assign bus.err    = err;
    assign bus.rd_cnt = rd_cnt;
    assign bus.wr_cnt = wr_cnt;

    // Zero-fill sweep after reset, then park in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_CLEAR;
            clr_ptr <= '0;
        end else if (state == S_CLEAR) begin
            clr_ptr <= clr_ptr + 1'b1;
            if (clr_ptr == '1) begin
                state <= S_IDLE;
            end
        end
    end

    // RAM write port: clear sweep has priority over core stores.
    always_ff @(posedge clk) begin
        if (!idle) begin
            mem[clr_ptr] <= '0;
        end else if (acc_wr) begin
            mem[idx] <= wr_word;
        end
    end

    // Registered read data, error pulse and saturating access counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ddatin <= '0;
            err    <= 1'b0;
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else begin
            err <= (bus.en & (~idle | ~in_range)) | par_err;
            if (idle) begin
                ddatin <= (bus.en & ~in_range) ? 32'h0 : rd_word[31:0];
            end
            if (acc_rd && rd_cnt != '1) begin
                rd_cnt <= rd_cnt + 1'b1;
            end
            if (acc_wr && wr_cnt != '1) begin
                wr_cnt <= wr_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_riscv_dmem_ctrl.sv
// Self-checking bench for riscv_dmem_ctrl (AW=4, CNT_W=2).
// Reference model plus literal checks on directed vectors.
module tb_riscv_dmem_ctrl;
    localparam int AW    = 4;
    localparam int CNT_W = 2;
    localparam int DEPTH = 16;
    localparam int CMAX  = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    riscv_dmem_ctrl_if #(.CNT_W(CNT_W)) bus ();

    riscv_dmem_ctrl #(.AW(AW), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_mem [DEPTH];
    logic        m_bad [DEPTH];
    int          clear_left = DEPTH;
    logic [31:0] m_ddatin = '0;
    logic        m_err = 1'b0;
    int          m_rd = 0;
    int          m_wr = 0;
    logic        flip_go = 1'b0;
    int          flip_idx = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: spec-level rules on word array and plain integer counters
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            clear_left <= DEPTH;
            m_ddatin   <= '0;
            m_err      <= 1'b0;
            m_rd       <= 0;
            m_wr       <= 0;
            for (int i = 0; i < DEPTH; i++) begin
                m_mem[i] <= '0;
                m_bad[i] <= 1'b0;
            end
        end else if (clear_left > 0) begin
            m_err      <= bus.en;
            clear_left <= clear_left - 1;
        end else if (flip_go) begin
            m_mem[flip_idx] <= m_mem[flip_idx] ^ 32'h1;
            m_bad[flip_idx] <= 1'b1;
            m_ddatin        <= m_mem[bus.mem_addr[5:2]];
            m_err           <= 1'b0;
        end else begin
            if (bus.en && bus.mem_addr[31:6] != 0) begin
                m_ddatin <= 32'h0;
                m_err    <= 1'b1;
            end else begin
                m_ddatin <= m_mem[bus.mem_addr[5:2]];
`ifdef DMEM_PARITY_EN
                m_err <= bus.en && !bus.rw && m_bad[bus.mem_addr[5:2]];
`else
                m_err <= 1'b0;
`endif
                if (bus.en && bus.rw) begin
                    m_mem[bus.mem_addr[5:2]] <= bus.ddatout;
                    m_bad[bus.mem_addr[5:2]] <= 1'b0;
                    m_wr <= (m_wr < CMAX) ? m_wr + 1 : CMAX;
                end else if (bus.en) begin
                    m_rd <= (m_rd < CMAX) ? m_rd + 1 : CMAX;
                end
            end
        end
    end

    // Compare DUT against model on every falling edge out of reset
    always @(negedge clk) begin
        if (rst) begin
            chk("m_busy", {31'b0, bus.busy}, {31'b0, clear_left != 0});
            chk("m_err", {31'b0, bus.err}, {31'b0, m_err});
            chk("m_ddatin", bus.ddatin, m_ddatin);
            chk("m_rd_cnt", 32'(bus.rd_cnt), 32'(m_rd));
            chk("m_wr_cnt", 32'(bus.wr_cnt), 32'(m_wr));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        bus.en       = e;
        bus.rw       = w;
        bus.mem_addr = a;
        bus.ddatout  = d;
    endtask

    int n;

    initial begin
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) tick();
        chk("rst_busy", {31'b0, bus.busy}, 32'h1);
        chk("rst_ddatin", bus.ddatin, 32'h0);
        chk("rst_err", {31'b0, bus.err}, 32'h0);
        chk("rst_cnt", 32'({bus.rd_cnt, bus.wr_cnt}), 32'h0);
        rst = 1'b1;

        // Zero-fill length, with a stray store during the sweep
        n = 0;
        while (bus.busy && n < 100) begin
            drive(n == 3, 1'b1, 32'h8, 32'hFFFF_FFFF);
            tick();
            n++;
            if (n == 4) chk("err_clear", {31'b0, bus.err}, 32'h1);
        end
        chk("clear_cycles", n, 16);
        drive(1'b0, 1'b0, 32'h0, 32'h0);

        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 1'b0, 32'(i * 4), 32'h0);
            tick();
            chk("zero_fill", bus.ddatin, 32'h0);
        end

        drive(1'b1, 1'b1, 32'h8, 32'hDEAD_BEEF);
        tick();
        drive(1'b1, 1'b0, 32'h8, 32'h0);
        tick();
        chk("rd_deadbeef", bus.ddatin, 32'hDEAD_BEEF);
        chk("wr_cnt_1", 32'(bus.wr_cnt), 32'd1);
        chk("rd_cnt_1", 32'(bus.rd_cnt), 32'd1);

        drive(1'b1, 1'b1, 32'h4, 32'h1);
        tick();
        chk("read_first_old", bus.ddatin, 32'h0);
        drive(1'b0, 1'b0, 32'h4, 32'h0);
        tick();
        chk("read_first_new", bus.ddatin, 32'h1);

        drive(1'b1, 1'b1, 32'h40, 32'h1234_5678);
        tick();
        chk("oor_err", {31'b0, bus.err}, 32'h1);
        chk("oor_ddatin", bus.ddatin, 32'h0);
        chk("oor_wr_cnt", 32'(bus.wr_cnt), 32'd2);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        chk("oor_err_clr", {31'b0, bus.err}, 32'h0);
        chk("oor_ram_kept", bus.ddatin, 32'h0);

        drive(1'b1, 1'b0, 32'h8000_0000, 32'h0);
        tick();
        chk("oor_rd_err", {31'b0, bus.err}, 32'h1);
        chk("oor_rd_cnt", 32'(bus.rd_cnt), 32'd1);

        drive(1'b1, 1'b0, 32'hB, 32'h0);
        tick();
        chk("misalign", bus.ddatin, 32'hDEAD_BEEF);

        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 32'h4, 32'h0);
            tick();
        end
        chk("rd_sat", 32'(bus.rd_cnt), 32'd3);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 32'(12 + i * 4), 32'(i + 7));
            tick();
        end
        chk("wr_sat", 32'(bus.wr_cnt), 32'd3);
        drive(1'b0, 1'b0, 32'hC, 32'h0);
        tick();
        chk("rd_word3", bus.ddatin, 32'h7);

`ifdef DMEM_PARITY_EN
        dut.mem[2] = dut.mem[2] ^ 33'h1;
        flip_idx = 2;
        flip_go  = 1'b1;
        tick();
        flip_go = 1'b0;
        drive(1'b1, 1'b0, 32'h8, 32'h0);
        tick();
        chk("par_err", {31'b0, bus.err}, 32'h1);
        chk("par_data", bus.ddatin, 32'hDEAD_BEEE);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
`endif

        drive(1'b1, 1'b1, 32'h10, 32'h0000_AAAA);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_busy", {31'b0, bus.busy}, 32'h1);
        chk("arst_ddatin", bus.ddatin, 32'h0);
        chk("arst_err", {31'b0, bus.err}, 32'h0);
        chk("arst_cnt", 32'({bus.rd_cnt, bus.wr_cnt}), 32'h0);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        rst = 1'b1;
        n = 0;
        while (bus.busy && n < 100) begin
            tick();
            n++;
        end
        chk("reclear_cycles", n, 16);
        drive(1'b0, 1'b0, 32'h10, 32'h0);
        tick();
        chk("lost_write", bus.ddatin, 32'h0);
        drive(1'b0, 1'b0, 32'h8, 32'h0);
        tick();
        chk("refill_zero", bus.ddatin, 32'h0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end
endmodule
